// File: rtl/core_pkg.sv
// Shared core types and the writeback match rule.
package core_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [XLEN-1:0] xlen_t;

  // x0 is hardwired, so a write to it never forwards.
  function automatic logic wb_hit(
    input logic     we,
    input reg_idx_t ws,
    input reg_idx_t idx
  );
    return we && (ws != '0) && (ws == idx);
  endfunction
endpackage

// File: rtl/operand_fwd.sv
// Per-operand forward select: live write, then
// latched bypass, then register-file data.
module operand_fwd
  import core_pkg::*;
(
  input  logic     wb_we,
  input  reg_idx_t wb_ws,
  input  xlen_t    wb_wd,
  input  reg_idx_t idx,
  input  logic     byp,
  input  xlen_t    byp_data,
  input  xlen_t    rf_data,
  output xlen_t    op
);
  always_comb begin
    op = rf_data;
    if (wb_hit(wb_we, wb_ws, idx)) op = wb_wd;
    else if (byp) op = byp_data;
  end
endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: read-pending slot R feeding
// output slot O, with writeback forwarding.
module operand_fetch #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [4:0]       in_rs1_i,
  input  logic [4:0]       in_rs2_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic [4:0]       rf_rs1_o,
  output logic [4:0]       rf_rs2_o,
  input  logic [XLEN-1:0]  rf_rd1_i,
  input  logic [XLEN-1:0]  rf_rd2_i,
  input  logic             wb_we_i,
  input  logic [4:0]       wb_ws_i,
  input  logic [XLEN-1:0]  wb_wd_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  out_op1_o,
  output logic [XLEN-1:0]  out_op2_o,
  output logic [TAG_W-1:0] out_tag_o
);
  logic             r_valid;
  logic [4:0]       r_rs1, r_rs2;
  logic [TAG_W-1:0] r_tag;
  logic             r_byp1, r_byp2;
  logic [XLEN-1:0]  r_bd1, r_bd2;
  logic [XLEN-1:0]  r_op1, r_op2;

  logic             o_valid;
  logic [4:0]       o_rs1, o_rs2;
  logic [XLEN-1:0]  o_op1, o_op2;
  logic [TAG_W-1:0] o_tag;

  logic r_adv, r_hold, accept;

  assign r_adv      = r_valid && (!o_valid || out_ready_i);
  assign r_hold     = r_valid && !r_adv;
  assign in_ready_o = !r_valid || r_adv;
  assign accept     = in_valid_i && in_ready_o;

  assign rf_rs1_o = r_hold ? r_rs1 : in_rs1_i;
  assign rf_rs2_o = r_hold ? r_rs2 : in_rs2_i;

  operand_fwd u_fwd1 (
    .wb_we    (wb_we_i),
    .wb_ws    (wb_ws_i),
    .wb_wd    (wb_wd_i),
    .idx      (r_rs1),
    .byp      (r_byp1),
    .byp_data (r_bd1),
    .rf_data  (rf_rd1_i),
    .op       (r_op1)
  );

  operand_fwd u_fwd2 (
    .wb_we    (wb_we_i),
    .wb_ws    (wb_ws_i),
    .wb_wd    (wb_wd_i),
    .idx      (r_rs2),
    .byp      (r_byp2),
    .byp_data (r_bd2),
    .rf_data  (rf_rd2_i),
    .op       (r_op2)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_tag   <= '0;
      r_byp1  <= 1'b0;
      r_byp2  <= 1'b0;
      r_bd1   <= '0;
      r_bd2   <= '0;
      o_valid <= 1'b0;
      o_rs1   <= '0;
      o_rs2   <= '0;
      o_op1   <= '0;
      o_op2   <= '0;
      o_tag   <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      if (accept) begin
        r_valid <= 1'b1;
        r_rs1   <= in_rs1_i;
        r_rs2   <= in_rs2_i;
        r_tag   <= in_tag_i;
      end else if (r_adv) begin
        r_valid <= 1'b0;
      end
      // RF returns pre-write data for a same-cycle write
      if (accept || r_hold) begin
        r_byp1 <= core_pkg::wb_hit(wb_we_i, wb_ws_i, rf_rs1_o);
        r_byp2 <= core_pkg::wb_hit(wb_we_i, wb_ws_i, rf_rs2_o);
        r_bd1  <= wb_wd_i;
        r_bd2  <= wb_wd_i;
      end
      if (r_adv) begin
        o_valid <= 1'b1;
        o_rs1   <= r_rs1;
        o_rs2   <= r_rs2;
        o_op1   <= r_op1;
        o_op2   <= r_op2;
        o_tag   <= r_tag;
      end else if (o_valid && out_ready_i) begin
        o_valid <= 1'b0;
      end else if (o_valid) begin
        if (core_pkg::wb_hit(wb_we_i, wb_ws_i, o_rs1))
          o_op1 <= wb_wd_i;
        if (core_pkg::wb_hit(wb_we_i, wb_ws_i, o_rs2))
          o_op2 <= wb_wd_i;
      end
    end
  end

  assign out_valid_o = o_valid;
  assign out_op1_o   = o_op1;
  assign out_op2_o   = o_op2;
  assign out_tag_o   = o_tag;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a
// registered-read register-file model.
module tb_operand_fetch;
  logic        clk, rst, flush;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2;
  logic [63:0] in_tag;
  logic [4:0]  rf_rs1, rf_rs2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        wb_we;
  logic [4:0]  wb_ws;
  logic [31:0] wb_wd;
  logic        out_valid, out_ready;
  logic [31:0] out_op1, out_op2;
  logic [63:0] out_tag;

  int total = 0;
  int bad = 0;

  logic [31:0] regs [32];

  operand_fetch #(.XLEN(32), .TAG_W(64)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_rs1_i    (in_rs1),
    .in_rs2_i    (in_rs2),
    .in_tag_i    (in_tag),
    .rf_rs1_o    (rf_rs1),
    .rf_rs2_o    (rf_rs2),
    .rf_rd1_i    (rf_rd1),
    .rf_rd2_i    (rf_rd2),
    .wb_we_i     (wb_we),
    .wb_ws_i     (wb_ws),
    .wb_wd_i     (wb_wd),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_op1_o   (out_op1),
    .out_op2_o   (out_op2),
    .out_tag_o   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: registered read returns the pre-write value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      rf_rd1 <= '0;
      rf_rd2 <= '0;
    end else begin
      if (wb_we && wb_ws != 5'd0) regs[wb_ws] <= wb_wd;
      rf_rd1 <= regs[rf_rs1];
      rf_rd2 <= regs[rf_rs2];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; in_rs1 = 0; in_rs2 = 0;
    in_tag = 0; wb_we = 0; wb_ws = 0; wb_wd = 0;
  endtask

  task automatic preload(input logic [4:0] r, input logic [31:0] v);
    wb_we = 1; wb_ws = r; wb_wd = v;
    step();
    wb_we = 0; wb_ws = 0; wb_wd = 0;
  endtask

  task automatic send(input logic [4:0] a, input logic [4:0] b,
                      input logic [63:0] t);
    in_valid = 1; in_rs1 = a; in_rs2 = b; in_tag = t;
  endtask

  task automatic test_reset();
    rst = 1; idle(); out_ready = 1;
    step(); step();
    rst = 0;
    total++; if (out_valid !== 1'b0) begin bad++;
      $display("FAIL rst_valid got=%b want=0", out_valid); end
    total++; if (out_op1 !== 32'h0) begin bad++;
      $display("FAIL rst_op1 got=%h want=0", out_op1); end
    total++; if (out_op2 !== 32'h0) begin bad++;
      $display("FAIL rst_op2 got=%h want=0", out_op2); end
    total++; if (out_tag !== 64'h0) begin bad++;
      $display("FAIL rst_tag got=%h want=0", out_tag); end
    total++; if (in_ready !== 1'b1) begin bad++;
      $display("FAIL rst_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_back_to_back();
    logic        ev;
    logic [63:0] et;
    preload(5'd1, 32'h11);
    preload(5'd2, 32'h22);
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) send(5'd1, 5'd2, 64'(100 + i));
      else in_valid = 0;
      ev = (i >= 2) && (i <= 4);
      et = 64'(100 + i - 2);
      total++; if (out_valid !== ev) begin bad++;
        $display("FAIL b2b_valid[%0d] got=%b want=%b", i, out_valid, ev); end
      total++; if (in_ready !== 1'b1) begin bad++;
        $display("FAIL b2b_ready[%0d] got=%b want=1", i, in_ready); end
      if (ev) begin
        total++; if (out_tag !== et) begin bad++;
          $display("FAIL b2b_tag[%0d] got=%h want=%h", i, out_tag, et); end
        total++; if (out_op1 !== 32'h11) begin bad++;
          $display("FAIL b2b_op1[%0d] got=%h want=11", i, out_op1); end
        total++; if (out_op2 !== 32'h22) begin bad++;
          $display("FAIL b2b_op2[%0d] got=%h want=22", i, out_op2); end
      end
      step();
    end
    idle();
  endtask

  task automatic test_same_cycle_bypass();
    out_ready = 1;
    send(5'd5, 5'd0, 64'd200);
    wb_we = 1; wb_ws = 5'd5; wb_wd = 32'hDEADBEEF;
    step(); idle(); step();
    total++; if (out_valid !== 1'b1 || out_tag !== 64'd200) begin bad++;
      $display("FAIL byp_out got=%b/%h want=1/c8", out_valid, out_tag); end
    total++; if (out_op1 !== 32'hDEADBEEF) begin bad++;
      $display("FAIL byp_op1 got=%h want=deadbeef", out_op1); end
    total++; if (out_op2 !== 32'h0) begin bad++;
      $display("FAIL byp_op2 got=%h want=0", out_op2); end
    step();
  endtask

  task automatic test_same_rs();
    out_ready = 1;
    send(5'd9, 5'd9, 64'd250);
    wb_we = 1; wb_ws = 5'd9; wb_wd = 32'h99;
    step(); idle(); step();
    total++; if (out_op1 !== 32'h99 || out_op2 !== 32'h99) begin bad++;
      $display("FAIL same_rs got=%h/%h want=99/99", out_op1, out_op2); end
    step();
  endtask

  task automatic test_arrival_write();
    out_ready = 1;
    send(5'd7, 5'd0, 64'd300);
    step(); idle();
    wb_we = 1; wb_ws = 5'd7; wb_wd = 32'hCAFE;
    step(); idle();
    total++; if (out_valid !== 1'b1 || out_tag !== 64'd300) begin bad++;
      $display("FAIL arr_out got=%b/%h want=1/12c", out_valid, out_tag); end
    total++; if (out_op1 !== 32'hCAFE) begin bad++;
      $display("FAIL arr_op1 got=%h want=cafe", out_op1); end
    step();
    send(5'd0, 5'd0, 64'd301);
    wb_we = 1; wb_ws = 5'd0; wb_wd = 32'hFFFF;
    step(); idle();
    wb_we = 1; wb_ws = 5'd0; wb_wd = 32'hFFFF;
    step(); idle();
    total++; if (out_tag !== 64'd301) begin bad++;
      $display("FAIL x0_tag got=%h want=12d", out_tag); end
    total++; if (out_op1 !== 32'h0 || out_op2 !== 32'h0) begin bad++;
      $display("FAIL x0_ops got=%h/%h want=0/0", out_op1, out_op2); end
    step();
  endtask

  task automatic test_stall();
    preload(5'd3, 32'h33);
    preload(5'd4, 32'h44);
    preload(5'd6, 32'h66);
    out_ready = 0;
    send(5'd3, 5'd4, 64'd400);
    step();
    send(5'd6, 5'd3, 64'd401);
    total++; if (in_ready !== 1'b1) begin bad++;
      $display("FAIL stall_ready1 got=%b want=1", in_ready); end
    step();
    send(5'd4, 5'd6, 64'd402);
    wb_we = 1; wb_ws = 5'd4; wb_wd = 32'hA4;
    total++; if (in_ready !== 1'b0) begin bad++;
      $display("FAIL stall_ready2 got=%b want=0", in_ready); end
    step();
    wb_ws = 5'd6; wb_wd = 32'hB6;
    total++; if (out_op2 !== 32'hA4 || out_tag !== 64'd400) begin bad++;
      $display("FAIL stall_o_upd got=%h/%h want=a4/190", out_op2, out_tag); end
    step();
    wb_we = 0;
    for (int i = 0; i < 2; i++) begin
      total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++;
        $display("FAIL stall_hold[%0d] got=%b/%b want=0/1", i, in_ready, out_valid); end
      total++; if (out_op1 !== 32'h33 || out_op2 !== 32'hA4) begin bad++;
        $display("FAIL stall_ops[%0d] got=%h/%h want=33/a4", i, out_op1, out_op2); end
      step();
    end
    out_ready = 1;
    total++; if (out_tag !== 64'd400) begin bad++;
      $display("FAIL stall_a_tag got=%h want=190", out_tag); end
    step();
    in_valid = 0;
    total++; if (out_tag !== 64'd401 || out_valid !== 1'b1) begin bad++;
      $display("FAIL stall_b_tag got=%h/%b want=191/1", out_tag, out_valid); end
    total++; if (out_op1 !== 32'hB6 || out_op2 !== 32'h33) begin bad++;
      $display("FAIL stall_b_ops got=%h/%h want=b6/33", out_op1, out_op2); end
    step();
    total++; if (out_tag !== 64'd402 || out_valid !== 1'b1) begin bad++;
      $display("FAIL stall_c_tag got=%h/%b want=192/1", out_tag, out_valid); end
    total++; if (out_op1 !== 32'hA4 || out_op2 !== 32'hB6) begin bad++;
      $display("FAIL stall_c_ops got=%h/%h want=a4/b6", out_op1, out_op2); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++;
      $display("FAIL stall_nodup got=%b want=0", out_valid); end
    idle();
  endtask

  task automatic test_flush();
    out_ready = 0;
    send(5'd1, 5'd2, 64'd500);
    step();
    send(5'd1, 5'd2, 64'd501);
    step();
    send(5'd1, 5'd2, 64'd502);
    flush = 1;
    step();
    flush = 0; in_valid = 0; out_ready = 1;
    total++; if (out_valid !== 1'b0) begin bad++;
      $display("FAIL flush_valid got=%b want=0", out_valid); end
    send(5'd1, 5'd2, 64'd503);
    flush = 1;
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      total++; if (out_valid !== 1'b0) begin bad++;
        $display("FAIL flush_gone[%0d] got=%b/%h want=0", i, out_valid, out_tag); end
      step();
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1;
    send(5'd1, 5'd2, 64'd600);
    step();
    send(5'd1, 5'd2, 64'd601);
    step();
    idle();
    rst = 1;
    step();
    rst = 0;
    total++; if (out_valid !== 1'b0) begin bad++;
      $display("FAIL mrst_valid got=%b want=0", out_valid); end
    total++; if (out_op1 !== 32'h0 || out_op2 !== 32'h0) begin bad++;
      $display("FAIL mrst_ops got=%h/%h want=0/0", out_op1, out_op2); end
    total++; if (out_tag !== 64'h0) begin bad++;
      $display("FAIL mrst_tag got=%h want=0", out_tag); end
    total++; if (in_ready !== 1'b1) begin bad++;
      $display("FAIL mrst_ready got=%b want=1", in_ready); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++;
      $display("FAIL mrst_nodrain got=%b want=0", out_valid); end
  endtask

  initial begin
    rst = 1; out_ready = 1; idle();
    test_reset();
    test_back_to_back();
    test_same_cycle_bypass();
    test_same_rs();
    test_arrival_write();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
